// File: rtl/fft_ram_pkg.sv
// Shared constants and state encoding for the FFT RAM frame reader.
package fft_ram_pkg;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry registered FIFO between the RAM read port and the output stream.
module fft_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;

    assign head_data  = mem0;
    assign head_valid = (count != 2'd0);

    // mem0 is always the head; the writer never pushes into a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end else begin
                        mem0 <= push_data;
                    end
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        mem0 <= push_data;
                    end else begin
                        mem1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fft_ram_reader.sv
// Streams one frame of words from a synchronous-read RAM onto a valid/ready
// interface, throttling reads so the skid FIFO can never overflow.
module fft_ram_reader
    import fft_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   frame_len,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_LEN = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    rd_state_t           state;
    logic [ADDR_WIDTH:0] remaining;
    logic [ADDR_WIDTH:0] len_clamped;
    logic                inflight;
    logic                inflight_last;
    logic [1:0]          fifo_count;
    logic [2:0]          occupancy;
    logic [2:0]          limit;
    logic                pop;
    logic                issue;
    logic                last_pop;
    logic [DATA_WIDTH:0] head;

    assign len_clamped = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;

    assign pop      = m_valid && m_ready;
    assign last_pop = pop && m_last;

    // A read is issued on the edge where the RAM samples ram_rd_addr;
    // its word lands on ram_rd_data for exactly one cycle after that.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign limit     = 3'd2 + {2'b00, pop};
    assign issue     = (state == ST_READ) && (occupancy < limit) && !abort;

    assign m_data = head[DATA_WIDTH-1:0];
    assign m_last = head[DATA_WIDTH];

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state         <= ST_IDLE;
            ram_rd_addr   <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state         <= ST_IDLE;
                remaining     <= '0;
                inflight      <= 1'b0;
                inflight_last <= 1'b0;
                busy          <= 1'b0;
            end else begin
                inflight      <= issue;
                inflight_last <= issue && (remaining == ONE_LEN);
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            ram_rd_addr <= start_addr;
                            remaining   <= len_clamped;
                            if (len_clamped == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= ST_READ;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (issue) begin
                            ram_rd_addr <= ram_rd_addr + ADDR_ONE;
                            remaining   <= remaining - ONE_LEN;
                            if (remaining == ONE_LEN) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (last_pop) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    fft_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .flush     (abort),
        .push      (inflight && !abort),
        .push_data ({inflight_last, ram_rd_data}),
        .pop       (pop),
        .head_data (head),
        .head_valid(m_valid),
        .count     (fifo_count)
    );

endmodule
